flash_prog_sequencer: RTL
=========================

// Module: flash_prog_sequencer
// PURPOSE
//  Tracks the JEDEC command sequences the CPU issues to PRG flash ($8000-$FFFF) during in-cart self-programming.
//  Gates flash write-enable so mapper-register writes cannot reach flash while a program/erase is in flight.
//  Sits between the mapper-register write latch and the flash_we term of the top level.
//  Supplies busy/done status to the mapper register file.
// PARAMETERS
//  CNT_W          24          width of busy timeout counter
//  UNLOCK_A1      12'hAAA     wr_addr[11:0] of first unlock cycle (byte mode)
//  UNLOCK_A2      12'h555     wr_addr[11:0] of second unlock cycle
//  PROG_TIMEOUT   64          busy cycles (m2) after byte program
//  SECTOR_TIMEOUT 1_800_000   busy cycles after sector erase (~1 s at 1.79 MHz)
//  CHIP_TIMEOUT   16_000_000  busy cycles after chip erase; must be < 2^CNT_W
// PORTS
//  m2                 in   1   CPU M2; sole clock, all state updates on rising edge
//  rst_n              in   1   synchronous active-low reset
//  prg_write_enabled  in   1   mapper config bit: self-programming permitted
//  wr_valid           in   1   1-cycle strobe: CPU write to ROM space ($8000-$FFFF) completed
//  wr_addr            in   15  cpu_addr_in of that write, stable while wr_valid=1
//  wr_data            in   8   data of that write, stable while wr_valid=1
//  flash_we_allow     out  1   registered; 1 = next ROM write may drive flash_we
//  busy               out  1   registered; 1 = program/erase timeout running
//  done               out  1   1-cycle pulse when busy falls
//  overrun            out  1   sticky; ROM write seen while busy
//  state_dbg          out  3   current state encoding
// BEHAVIOUR
//  Reset (rst_n=0 at rising m2): state=IDLE, counter=0, flash_we_allow=0, busy=0, done=0, overrun=0.
//  A "hit" means wr_valid=1 on that edge; addr compare uses wr_addr[11:0] only.
//  States (state_dbg): IDLE=0 U1=1 U2=2 PROG=3 E_U0=4 E_U1=5 E_CMD=6 BUSY=7.
//  IDLE : hit AA@A1 -> U1; other hits stay IDLE.
//  U1   : hit 55@A2 -> U2; any other hit -> IDLE.
//  U2   : hit A0 (any addr) -> PROG; 80 -> E_U0; F0 or anything else -> IDLE.
//  PROG : any hit -> BUSY, counter=PROG_TIMEOUT (that write is the data byte).
//  E_U0 : hit AA@A1 -> E_U1; else -> IDLE.   E_U1: hit 55@A2 -> E_CMD; else -> IDLE.
//  E_CMD: hit 30 (any addr) -> BUSY, counter=SECTOR_TIMEOUT; 10@A1 -> BUSY, counter=CHIP_TIMEOUT;
//         any other hit -> IDLE.
//  Non-hit cycles never change state outside BUSY (no inter-write timeout).
//  BUSY : counter decrements every m2 edge; on the edge where counter==1 -> IDLE, counter=0, done=1 next cycle.
//         Hits in BUSY are ignored for sequencing and set overrun=1 (cleared only by reset).
//  Latency: state/busy/flash_we_allow update on the same edge that samples the hit, visible one cycle later.
//  flash_we_allow <= prg_write_enabled & (next_state != BUSY); hence it drops the cycle after the data or
//    erase-confirm write, and is 0 throughout BUSY.
//  busy <= (next_state == BUSY); done <= (state==BUSY && next_state==IDLE).
//  prg_write_enabled=0: any non-BUSY state is forced to IDLE on that edge (no hit decoding); BUSY continues
//    to completion, since flash is already executing the command.
//  prg_write_enabled=0 and hit on the same edge: the force to IDLE takes priority.
//  Counter never wraps: load values are checked against 2^CNT_W at elaboration; a timeout of 0 is treated as 1.
//  Reset asserted mid-BUSY aborts the timeout immediately; done is not pulsed.
// TESTING
//  1. prg_write_enabled=1; AA@AAA, 55@555, A0@x, 5C@8123 -> busy=1 and flash_we_allow=0 next cycle;
//     64 cycles later done pulses once and flash_we_allow=1.
//  2. Sector erase AA,55,80,AA,55,30@C000 -> busy for 1_800_000 cycles; an extra write at cycle 10 -> overrun=1
//     and busy length unchanged.
//  3. AA@AAA, 12@555 -> state_dbg=0; then AA@AAA, 55@555, F0 -> state_dbg=0 and busy never asserted.
//  4. Drop prg_write_enabled while in U2 -> state_dbg=0 and flash_we_allow=0 next cycle;
//     drop it during BUSY -> busy still completes and done pulses.
//  5. rst_n=0 for one edge at BUSY counter=30 -> all outputs 0, state_dbg=0, no done pulse.
//  6. Chip erase AA,55,80,AA,55,10@AAA -> counter loaded with 16_000_000; 10@123 instead -> IDLE.

Source files
------------

// File: rtl/flash_prog_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flash_prog_sequencer_if : ROM-space write strobe bus from the mapper latch |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface flash_prog_sequencer_if;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/flash_prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flash_prog_sequencer : JEDEC program/erase tracker gating PRG flash writes |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module flash_prog_sequencer #(
  parameter int          CNT_W          = 24,
  parameter logic [11:0] UNLOCK_A1      = 12'hAAA,
  parameter logic [11:0] UNLOCK_A2      = 12'h555,
  parameter int          PROG_TIMEOUT   = 64,
  parameter int          SECTOR_TIMEOUT = 1_800_000,
  parameter int          CHIP_TIMEOUT   = 16_000_000
) (
  input  wire logic                  m2,
  input  wire logic                  rst_n,
  input  wire logic                  prg_write_enabled,
  flash_prog_sequencer_if.slave      bus,
  output logic                       flash_we_allow,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_U1    = 3'd1,
    S_U2    = 3'd2,
    S_PROG  = 3'd3,
    S_E_U0  = 3'd4,
    S_E_U1  = 3'd5,
    S_E_CMD = 3'd6,
    S_BUSY  = 3'd7
  } state_t;

  // A zero timeout would leave BUSY stuck, so it is clamped to one cycle.
  localparam int c_prog_int   = (PROG_TIMEOUT   < 1) ? 1 : PROG_TIMEOUT;
  localparam int c_sector_int = (SECTOR_TIMEOUT < 1) ? 1 : SECTOR_TIMEOUT;
  localparam int c_chip_int   = (CHIP_TIMEOUT   < 1) ? 1 : CHIP_TIMEOUT;
  localparam logic [CNT_W-1:0] c_prog_load   = CNT_W'(c_prog_int);
  localparam logic [CNT_W-1:0] c_sector_load = CNT_W'(c_sector_int);
  localparam logic [CNT_W-1:0] c_chip_load   = CNT_W'(c_chip_int);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero        = '0;

  generate
    if ((longint'(c_prog_int)   >= (longint'(1) << CNT_W)) ||
        (longint'(c_sector_int) >= (longint'(1) << CNT_W)) ||
        (longint'(c_chip_int)   >= (longint'(1) << CNT_W))) begin : g_timeout_range_err
      $error("flash_prog_sequencer: a timeout does not fit in CNT_W bits");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_we_allow;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;

  logic w_hit;
  logic w_at_a1;
  logic w_at_a2;
  logic w_unlock1;
  logic w_unlock2;
  logic w_unused_addr_hi;

  assign w_hit            = bus.wr_valid;
  assign w_at_a1          = (bus.wr_addr[11:0] == UNLOCK_A1);
  assign w_at_a2          = (bus.wr_addr[11:0] == UNLOCK_A2);
  assign w_unlock1        = (bus.wr_data == 8'hAA) && w_at_a1;
  assign w_unlock2        = (bus.wr_data == 8'h55) && w_at_a2;
  assign w_unused_addr_hi = ^bus.wr_addr[14:12];

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (r_state == S_BUSY) begin
      // Flash is already executing; BUSY runs out regardless of enable or writes.
      if (r_cnt <= c_one) begin
        w_next_state = S_IDLE;
        w_next_cnt   = c_zero;
      end else begin
        w_next_cnt   = r_cnt - c_one;
      end
    end else if (!prg_write_enabled) begin
      w_next_state = S_IDLE;
    end else if (w_hit) begin
      w_next_state = S_IDLE;
      case (r_state)
        S_IDLE:  if (w_unlock1) w_next_state = S_U1;
        S_U1:    if (w_unlock2) w_next_state = S_U2;
        S_U2: begin
          if (bus.wr_data == 8'hA0)      w_next_state = S_PROG;
          else if (bus.wr_data == 8'h80) w_next_state = S_E_U0;
        end
        S_PROG: begin
          w_next_state = S_BUSY;
          w_next_cnt   = c_prog_load;
        end
        S_E_U0:  if (w_unlock1) w_next_state = S_E_U1;
        S_E_U1:  if (w_unlock2) w_next_state = S_E_CMD;
        S_E_CMD: begin
          if (bus.wr_data == 8'h30) begin
            w_next_state = S_BUSY;
            w_next_cnt   = c_sector_load;
          end else if ((bus.wr_data == 8'h10) && w_at_a1) begin
            w_next_state = S_BUSY;
            w_next_cnt   = c_chip_load;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= c_zero;
      r_we_allow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_we_allow <= prg_write_enabled && (w_next_state != S_BUSY);
      r_busy     <= (w_next_state == S_BUSY);
      r_done     <= (r_state == S_BUSY) && (w_next_state == S_IDLE);
      if ((r_state == S_BUSY) && w_hit) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign flash_we_allow = r_we_allow;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overrun        = r_overrun;
  assign state_dbg      = r_state;

endmodule
`default_nettype wire
